// File: rtl/dot_arbiter.sv
// Round-robin arbiter that shares one dot-product unit among NREQ requesters.
// Optional watchdog on the unit's completion, enabled by defining DOT_ARB_TIMEOUT_EN.
module dot_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int EXT_DIM    = 4,
  parameter int NREQ       = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREQ-1:0]                    req_start,
  input  logic [NREQ*EXT_DIM*DATA_WIDTH-1:0] req_vec_a,
  input  logic [NREQ*EXT_DIM*DATA_WIDTH-1:0] req_vec_b,
  output logic [NREQ-1:0]                    req_grant,
  output logic [NREQ-1:0]                    req_done,
  output logic [DATA_WIDTH-1:0]              req_result,
  output logic [EXT_DIM*DATA_WIDTH-1:0]      vector_a,
  output logic [EXT_DIM*DATA_WIDTH-1:0]      vector_b,
  output logic                               start_dot_product,
  output logic                               rstn_dot,
  input  logic                               dot_product_done,
  input  logic [DATA_WIDTH-1:0]              dot_product_result,
  output logic                               arb_err
);

  localparam int VW = EXT_DIM * DATA_WIDTH;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            found;

  // First pending requester after last_grant, wrapping around.
  always_comb begin
    pick  = last_grant;
    cand  = last_grant;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((last_grant + i) % NREQ);
      if (!found && req_start[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef DOT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT == 0);
  assign arb_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      last_grant        <= IW'(NREQ - 1);
      gnt_idx           <= '0;
      req_grant         <= '0;
      req_done          <= '0;
      req_result        <= '0;
      vector_a          <= '0;
      vector_b          <= '0;
      start_dot_product <= 1'b0;
      rstn_dot          <= 1'b0;
`ifdef DOT_ARB_TIMEOUT_EN
      wd_cnt            <= '0;
      arb_err           <= 1'b0;
`endif
    end else begin
      req_done <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt_idx   <= pick;
            req_grant <= NREQ'(1) << pick;
            vector_a  <= req_vec_a[pick*VW +: VW];
            vector_b  <= req_vec_b[pick*VW +: VW];
            rstn_dot  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          start_dot_product <= 1'b1;
`ifdef DOT_ARB_TIMEOUT_EN
          wd_cnt            <= '0;
`endif
          state             <= WAIT;
        end
        WAIT: begin
          if (dot_product_done) begin
            req_result        <= dot_product_result;
            req_done          <= req_grant;
            start_dot_product <= 1'b0;
            rstn_dot          <= 1'b0;
            last_grant        <= gnt_idx;
            state             <= RELEASE;
          end
`ifdef DOT_ARB_TIMEOUT_EN
          else if (wd_cnt == TW'(TIMEOUT - 1)) begin
            req_result        <= '0;
            req_done          <= req_grant;
            start_dot_product <= 1'b0;
            rstn_dot          <= 1'b0;
            last_grant        <= gnt_idx;
            arb_err           <= 1'b1;
            state             <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!req_start[gnt_idx]) begin
            req_grant <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
